// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the ARM-subset pipeline.
//   alu_op_t   : ALU operation encoding (matches ALUControl field)
//   COND_*     : ARM condition codes
//   FLAG_*     : bit positions of {N,Z,C,V} in the flag register
//   fwd_sel_t  : operand forwarding source select
//   cond_holds : evaluates a condition code against an NZCV value
package pipe_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_t;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    c = f[FLAG_C];
    v = f[FLAG_V];
    case (cond)
      COND_EQ: cond_holds = z;
      COND_NE: cond_holds = !z;
      COND_CS: cond_holds = c;
      COND_CC: cond_holds = !c;
      COND_MI: cond_holds = n;
      COND_PL: cond_holds = !n;
      COND_VS: cond_holds = v;
      COND_VC: cond_holds = !v;
      COND_HI: cond_holds = c & !z;
      COND_LS: cond_holds = !c | z;
      COND_GE: cond_holds = (n == v);
      COND_LT: cond_holds = (n != v);
      COND_GT: cond_holds = !z & (n == v);
      COND_LE: cond_holds = z | (n != v);
      default: cond_holds = 1'b1;  // AL and 1111
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// alu: combinational ALU for the execute stage.
//   a, b   : operands (WIDTH)
//   op     : ADD / SUB / AND / ORR
//   result : operation result (WIDTH)
//   flags  : {N,Z,C,V}; C,V forced to 0 for logical ops
module alu
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             cin;

  always_comb begin
    cin    = (op == ALU_SUB);
    b_eff  = cin ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    result = '0;
    flags  = '0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        result         = sum[WIDTH-1:0];
        flags[FLAG_C]  = sum[WIDTH];
        flags[FLAG_V]  = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      default: result = a | b;
    endcase
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
  end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: execute stage with operand forwarding, ALU, condition
// evaluation against an internal NZCV register, and Execute/Memory register.
//   Inputs : D/E bundle (rdo1, rdo2, exto, ao3, RA1E, RA2E, controls,
//            ALUControlE, FlagWriteE, CondE), W forwarding (ResultW, WA3W,
//            RegWriteW)
//   Outputs: registered M bundle (ALUOutM, WriteDataM, WA3M, RegWriteM,
//            MemWriteM, MemtoRegM, PCSrcM), combinational BranchTakenE and
//            ALUResultE, flag register FlagsQ {N,Z,C,V}
// Macro EXEC_FORWARD_EN: when defined, M/W forwarding muxes are active;
// otherwise operands come straight from rdo1/rdo2.
module execute_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADDR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rdo1,
  input  logic [WIDTH-1:0] rdo2,
  input  logic [WIDTH-1:0] exto,
  input  logic [RADDR-1:0] ao3,
  input  logic [RADDR-1:0] RA1E,
  input  logic [RADDR-1:0] RA2E,
  input  logic             PCSrcE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             MemWriteE,
  input  logic             BranchE,
  input  logic             ALUSrcE,
  input  logic [1:0]       ALUControlE,
  input  logic [1:0]       FlagWriteE,
  input  logic [3:0]       CondE,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [RADDR-1:0] WA3W,
  input  logic             RegWriteW,
  output logic [WIDTH-1:0] ALUOutM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [RADDR-1:0] WA3M,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemtoRegM,
  output logic             PCSrcM,
  output logic             BranchTakenE,
  output logic [WIDTH-1:0] ALUResultE,
  output logic [3:0]       FlagsQ
);

  fwd_sel_t         sel_a, sel_b;
  logic [WIDTH-1:0] src_a, fwd_b, src_b;
  logic [3:0]       alu_flags;
  logic             cond_ex;

`ifdef EXEC_FORWARD_EN
  // Memory stage is checked first so the younger result wins.
  always_comb begin
    sel_a = FWD_REG;
    sel_b = FWD_REG;
    if (RegWriteM && (WA3M == RA1E))      sel_a = FWD_MEM;
    else if (RegWriteW && (WA3W == RA1E)) sel_a = FWD_WB;
    if (RegWriteM && (WA3M == RA2E))      sel_b = FWD_MEM;
    else if (RegWriteW && (WA3W == RA2E)) sel_b = FWD_WB;
  end
`else
  logic fwd_unused;
  assign fwd_unused = ^{RA1E, RA2E, WA3W, RegWriteW};
  always_comb begin
    sel_a = FWD_REG;
    sel_b = FWD_REG;
  end
`endif

  always_comb begin
    case (sel_a)
      FWD_MEM: src_a = ALUOutM;
      FWD_WB:  src_a = ResultW;
      default: src_a = rdo1;
    endcase
    case (sel_b)
      FWD_MEM: fwd_b = ALUOutM;
      FWD_WB:  fwd_b = ResultW;
      default: fwd_b = rdo2;
    endcase
    src_b = ALUSrcE ? exto : fwd_b;
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (src_a),
    .b      (src_b),
    .op     (alu_op_t'(ALUControlE)),
    .result (ALUResultE),
    .flags  (alu_flags)
  );

  // Condition uses the flags as they stand before this instruction's update.
  assign cond_ex      = cond_holds(CondE, FlagsQ);
  assign BranchTakenE = BranchE & cond_ex;

  always_ff @(posedge clk) begin
    if (rst) begin
      FlagsQ <= '0;
    end else begin
      if (FlagWriteE[1] && cond_ex) begin
        FlagsQ[FLAG_N] <= alu_flags[FLAG_N];
        FlagsQ[FLAG_Z] <= alu_flags[FLAG_Z];
      end
      if (FlagWriteE[0] && cond_ex) begin
        FlagsQ[FLAG_C] <= alu_flags[FLAG_C];
        FlagsQ[FLAG_V] <= alu_flags[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WA3M       <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      PCSrcM     <= 1'b0;
    end else begin
      ALUOutM    <= ALUResultE;
      WriteDataM <= fwd_b;
      WA3M       <= ao3;
      RegWriteM  <= RegWriteE & cond_ex;
      MemWriteM  <= MemWriteE & cond_ex;
      MemtoRegM  <= MemtoRegE;
      PCSrcM     <= PCSrcE & cond_ex;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rdo1, rdo2, exto, ResultW;
  logic [3:0]  ao3, RA1E, RA2E, WA3W, CondE;
  logic        PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegWriteW;
  logic [1:0]  ALUControlE, FlagWriteE;
  logic [31:0] ALUOutM, WriteDataM, ALUResultE;
  logic [3:0]  WA3M, FlagsQ;
  logic        RegWriteM, MemWriteM, MemtoRegM, PCSrcM, BranchTakenE;

  always #5 clk = ~clk;

  execute_stage #(.WIDTH(32), .RADDR(4)) dut (
    .clk(clk), .rst(rst), .rdo1(rdo1), .rdo2(rdo2), .exto(exto), .ao3(ao3),
    .RA1E(RA1E), .RA2E(RA2E), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .FlagWriteE(FlagWriteE),
    .CondE(CondE), .ResultW(ResultW), .WA3W(WA3W), .RegWriteW(RegWriteW),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WA3M(WA3M),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .PCSrcM(PCSrcM), .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE),
    .FlagsQ(FlagsQ)
  );

  typedef struct {
    logic        rst;
    logic [31:0] rdo1, rdo2, exto, resw;
    logic [3:0]  ao3, ra1, ra2, wa3w, cond;
    logic        pcs, rw, mtr, mw, br, alusrc, rww;
    logic [1:0]  aluc, fw;
  } instr_t;

  typedef struct {
    logic [31:0] alu_m, wd_m, alu_e;
    logic [3:0]  wa3_m, flags;
    logic        rw_m, mw_m, mtr_m, pcs_m, bt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 0;

  // Reference state: what the M register and flags should hold right now.
  logic [31:0] m_alu, m_wd;
  logic [3:0]  m_wa3, m_flags;
  logic        m_rw, m_mw, m_mtr, m_pcs;

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    case (c)
      0: return z;            1: return !z;
      2: return cy;           3: return !cy;
      4: return n;            5: return !n;
      6: return v;            7: return !v;
      8: return cy && !z;     9: return !cy || z;
      10: return n == v;      11: return n != v;
      12: return !z && n == v; 13: return z || n != v;
      default: return 1'b1;
    endcase
  endfunction

  // Arithmetic reference: carry from unsigned widened sum, overflow from
  // whether the signed sum leaves the 32-bit signed range.
  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] op,
                                  output logic [31:0] r, output logic [3:0] f);
    longint unsigned us;
    longint          ss;
    logic [31:0]     bp;
    int              cin;
    f = 4'b0000;
    case (op)
      2'b00, 2'b01: begin
        cin = (op == 2'b01) ? 1 : 0;
        bp  = (op == 2'b01) ? ~b : b;
        us  = longint'(a) + longint'(bp) + longint'(cin);
        ss  = longint'($signed(a)) + longint'($signed(bp)) + longint'(cin);
        r   = us[31:0];
        f[1] = us[32];
        f[0] = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      2'b10: r = a & b;
      default: r = a | b;
    endcase
    f[3] = r[31];
    f[2] = (r == 32'd0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Called just after a rising edge: drive the bundle, queue the expected
  // observable state for the coming falling edge, then advance the model.
  task automatic step(input instr_t i);
    exp_t        e;
    logic [31:0] a, fb, sb, r;
    logic [3:0]  f;
    logic        ce;
    rst = i.rst; rdo1 = i.rdo1; rdo2 = i.rdo2; exto = i.exto; ResultW = i.resw;
    ao3 = i.ao3; RA1E = i.ra1; RA2E = i.ra2; WA3W = i.wa3w; CondE = i.cond;
    PCSrcE = i.pcs; RegWriteE = i.rw; MemtoRegE = i.mtr; MemWriteE = i.mw;
    BranchE = i.br; ALUSrcE = i.alusrc; RegWriteW = i.rww;
    ALUControlE = i.aluc; FlagWriteE = i.fw;

    a  = i.rdo1;
    fb = i.rdo2;
`ifdef EXEC_FORWARD_EN
    if (m_rw && m_wa3 == i.ra1)       a = m_alu;
    else if (i.rww && i.wa3w == i.ra1) a = i.resw;
    if (m_rw && m_wa3 == i.ra2)       fb = m_alu;
    else if (i.rww && i.wa3w == i.ra2) fb = i.resw;
`endif
    sb = i.alusrc ? i.exto : fb;
    ref_alu(a, sb, i.aluc, r, f);
    ce = cond_ok(i.cond, m_flags);

    e.alu_m = m_alu; e.wd_m = m_wd; e.wa3_m = m_wa3; e.flags = m_flags;
    e.rw_m = m_rw; e.mw_m = m_mw; e.mtr_m = m_mtr; e.pcs_m = m_pcs;
    e.alu_e = r; e.bt = i.br && ce;
    q.push_back(e);

    if (i.rst) begin
      m_alu = '0; m_wd = '0; m_wa3 = '0; m_flags = '0;
      m_rw = 0; m_mw = 0; m_mtr = 0; m_pcs = 0;
    end else begin
      if (ce && i.fw[1]) m_flags[3:2] = f[3:2];
      if (ce && i.fw[0]) m_flags[1:0] = f[1:0];
      m_alu = r; m_wd = fb; m_wa3 = i.ao3;
      m_rw = i.rw && ce; m_mw = i.mw && ce; m_pcs = i.pcs && ce; m_mtr = i.mtr;
    end
    @(posedge clk); #1;
  endtask

  function automatic instr_t nop();
    instr_t i;
    i.rst = 0; i.rdo1 = 0; i.rdo2 = 0; i.exto = 0; i.resw = 0;
    i.ao3 = 0; i.ra1 = 0; i.ra2 = 0; i.wa3w = 0; i.cond = 4'b1110;
    i.pcs = 0; i.rw = 0; i.mtr = 0; i.mw = 0; i.br = 0; i.alusrc = 0; i.rww = 0;
    i.aluc = 0; i.fw = 0;
    return i;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.rst = ($urandom_range(0, 24) == 0);
    i.rdo1 = rand_word(); i.rdo2 = rand_word(); i.exto = rand_word(); i.resw = rand_word();
    i.ao3 = 4'($urandom_range(0, 3)); i.ra1 = 4'($urandom_range(0, 3));
    i.ra2 = 4'($urandom_range(0, 3)); i.wa3w = 4'($urandom_range(0, 3));
    if ($urandom_range(0, 9) == 0) i.ao3 = 4'd15;
    i.cond = 4'($urandom_range(0, 15));
    i.pcs = 1'($urandom); i.rw = 1'($urandom); i.mtr = 1'($urandom);
    i.mw = 1'($urandom); i.br = 1'($urandom); i.alusrc = 1'($urandom);
    i.rww = 1'($urandom);
    i.aluc = 2'($urandom); i.fw = 2'($urandom);
    return i;
  endfunction

  // Monitor: one queued expectation per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ALUOutM",      ALUOutM,      e.alu_m);
        check("WriteDataM",   WriteDataM,   e.wd_m);
        check("WA3M",         {28'd0, WA3M},   {28'd0, e.wa3_m});
        check("RegWriteM",    {31'd0, RegWriteM}, {31'd0, e.rw_m});
        check("MemWriteM",    {31'd0, MemWriteM}, {31'd0, e.mw_m});
        check("MemtoRegM",    {31'd0, MemtoRegM}, {31'd0, e.mtr_m});
        check("PCSrcM",       {31'd0, PCSrcM},    {31'd0, e.pcs_m});
        check("FlagsQ",       {28'd0, FlagsQ},    {28'd0, e.flags});
        check("BranchTakenE", {31'd0, BranchTakenE}, {31'd0, e.bt});
        check("ALUResultE",   ALUResultE,   e.alu_e);
      end
    end
  end

  initial begin
    instr_t i;
    m_alu = '0; m_wd = '0; m_wa3 = '0; m_flags = '0;
    m_rw = 0; m_mw = 0; m_mtr = 0; m_pcs = 0;
    i = nop(); i.rst = 1;
    rst = 1; rdo1 = 0; rdo2 = 0; exto = 0; ResultW = 0; ao3 = 0; RA1E = 0;
    RA2E = 0; WA3W = 0; CondE = 4'b1110; PCSrcE = 0; RegWriteE = 0;
    MemtoRegE = 0; MemWriteE = 0; BranchE = 0; ALUSrcE = 0; RegWriteW = 0;
    ALUControlE = 0; FlagWriteE = 0;
    @(posedge clk); #1;
    step(i);

    // SUB 5-5 setting all flags -> Z,C
    i = nop(); i.rdo1 = 5; i.rdo2 = 5; i.aluc = 2'b01; i.fw = 2'b11; step(i);
    // EQ ADD writing R3, then NE with writes (must bubble)
    i = nop(); i.cond = 4'b0000; i.rw = 1; i.ao3 = 3; i.rdo1 = 1; i.rdo2 = 2; step(i);
    i = nop(); i.cond = 4'b0001; i.rw = 1; i.mw = 1; i.pcs = 1; i.fw = 2'b11; i.rdo1 = 9; step(i);
    // 0x7FFFFFFF + 1 -> N,V
    i = nop(); i.rdo1 = 32'h7FFF_FFFF; i.rdo2 = 1; i.fw = 2'b11; step(i);
    // forwarding: R2 <= 0xA, then read R2 with W also matching
    i = nop(); i.rdo1 = 32'hA; i.alusrc = 1; i.rw = 1; i.ao3 = 2; step(i);
    i = nop(); i.ra1 = 2; i.wa3w = 2; i.rww = 1; i.resw = 32'hB; step(i);
    i = nop(); i.ra1 = 2; i.wa3w = 2; i.rww = 1; i.resw = 32'hB; step(i);
    // GT branch: clear flags (1+1), then set Z (0+0)
    i = nop(); i.rdo1 = 1; i.rdo2 = 1; i.fw = 2'b11; step(i);
    i = nop(); i.br = 1; i.cond = 4'b1100; i.fw = 2'b11; step(i);
    i = nop(); i.br = 1; i.cond = 4'b1100; step(i);
    // reset coincident with a flag-setting SUB
    i = nop(); i.rst = 1; i.rdo1 = 3; i.rdo2 = 7; i.aluc = 2'b01; i.fw = 2'b11;
    i.rw = 1; i.ao3 = 5; step(i);
    // flushed bundle
    i = nop(); i.cond = 4'b0000; step(i);

    for (int k = 0; k < 400; k++) begin
      i = rand_instr();
      step(i);
    end
    i = nop(); step(i);
    stim_done = 1;

    repeat (3) @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
